// File: rtl/mux_253_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_253_arbiter
// Purpose  : Round-robin arbiter for a shared 74x253 dual 4:1 tristate mux,
//            with one dead turnaround cycle between bus owners.
//            Optional forced rotation: define MUX_253_ARBITER_HOLD_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux_253_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [7:0] lane,
    output logic [1:0] sel,
    output logic       noe1,
    output logic       noe2,
    output logic [3:0] gnt,
    output logic       busy
);

    localparam logic [1:0]        c_IDLE     = 2'd0;
    localparam logic [1:0]        c_TURN     = 2'd1;
    localparam logic [1:0]        c_GRANT    = 2'd2;
    localparam logic [HOLD_W-1:0] c_HOLD_SAT = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        r_state, w_state_nx;
    logic [1:0]        r_sel,   w_sel_nx;
    logic              r_noe1,  w_noe1_nx;
    logic              r_noe2,  w_noe2_nx;
    logic [3:0]        r_gnt,   w_gnt_nx;
    logic              r_busy,  w_busy_nx;
    logic [HOLD_W-1:0] r_hold,  w_hold_nx;
    logic [1:0]        r_ptr,   w_ptr_nx;

    logic [3:0]        w_own_mask;
    logic [3:0]        w_others;
    logic [1:0]        w_idle_win;
    logic [1:0]        w_next_win;
    logic              w_release;

    // First set bit strictly after base, wrapping; base itself has lowest priority.
    function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        f_pick = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) f_pick = idx;
        end
    endfunction

    assign w_own_mask = 4'b0001 << r_sel;
    assign w_others   = req & ~w_own_mask;
    assign w_idle_win = f_pick(req, r_ptr);
    assign w_next_win = f_pick(w_others, r_sel);

`ifdef MUX_253_ARBITER_HOLD_LIMIT_EN
    assign w_release = ~req[r_sel] | ((r_hold == c_HOLD_SAT) & (|w_others));
`else
    assign w_release = ~req[r_sel];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_sel   <= 2'd0;
            r_noe1  <= 1'b1;
            r_noe2  <= 1'b1;
            r_gnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
            r_ptr   <= 2'd3;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_noe1  <= w_noe1_nx;
            r_noe2  <= w_noe2_nx;
            r_gnt   <= w_gnt_nx;
            r_busy  <= w_busy_nx;
            r_hold  <= w_hold_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_noe1_nx  = r_noe1;
        w_noe2_nx  = r_noe2;
        w_gnt_nx   = r_gnt;
        w_busy_nx  = r_busy;
        w_hold_nx  = r_hold;
        w_ptr_nx   = r_ptr;
        case (r_state)
            c_IDLE: begin
                if (|req) begin
                    w_state_nx = c_TURN;
                    w_sel_nx   = w_idle_win;
                    w_busy_nx  = 1'b1;
                end
            end
            c_TURN: begin
                // Lane choice is captured once here and frozen for the whole grant.
                w_state_nx = c_GRANT;
                w_gnt_nx   = w_own_mask;
                w_hold_nx  = '0;
                w_noe1_nx  = ~lane[{r_sel, 1'b0}];
                w_noe2_nx  = ~lane[{r_sel, 1'b1}];
            end
            c_GRANT: begin
                if (r_hold != c_HOLD_SAT) w_hold_nx = r_hold + 1'b1;
                if (w_release) begin
                    w_ptr_nx  = r_sel;
                    w_noe1_nx = 1'b1;
                    w_noe2_nx = 1'b1;
                    w_gnt_nx  = 4'd0;
                    if (|w_others) begin
                        w_state_nx = c_TURN;
                        w_sel_nx   = w_next_win;
                    end else begin
                        w_state_nx = c_IDLE;
                        w_busy_nx  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nx = c_IDLE;
                w_noe1_nx  = 1'b1;
                w_noe2_nx  = 1'b1;
                w_gnt_nx   = 4'd0;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_comb begin
        sel  = r_sel;
        noe1 = r_noe1;
        noe2 = r_noe2;
        gnt  = r_gnt;
        busy = r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_253_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_253_arbiter
// Purpose  : Self-checking bench: vector table, corner sequences and random
//            traffic against a behavioural owner/pending model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_253_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef MUX_253_ARBITER_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] lane;
    logic [1:0] sel;
    logic       noe1;
    logic       noe2;
    logic [3:0] gnt;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    mux_253_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lane  (lane),
        .sel   (sel),
        .noe1  (noe1),
        .noe2  (noe2),
        .gnt   (gnt),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model: who owns the bus, who is waiting out the dead cycle.
    int m_owner, m_pend, m_ptr, m_sel, m_hold;
    bit m_noe1, m_noe2;
    logic [3:0] prev_gnt = 4'd0;

    function automatic int pick(input logic [3:0] r, input int base);
        for (int k = 1; k <= 4; k++)
            if (r[(base + k) % 4]) return (base + k) % 4;
        return -1;
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        for (int k = 0; k < 4; k++)
            if (g[k]) return k;
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] q, input logic [7:0] l);
        logic [3:0] others;
        bit rel;
        if (r) begin
            m_owner = -1; m_pend = -1; m_ptr = 3; m_sel = 0; m_hold = 0;
            m_noe1 = 1'b1; m_noe2 = 1'b1;
        end else if (m_owner >= 0) begin
            others = q & ~4'(1 << m_owner);
            rel = !q[m_owner] || (HOLD_EN && m_hold == MAX_HOLD - 1 && others != 4'd0);
            if (rel) begin
                m_ptr = m_owner; m_owner = -1; m_noe1 = 1'b1; m_noe2 = 1'b1;
                m_pend = pick(others, m_ptr);
                if (m_pend >= 0) m_sel = m_pend;
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end
        end else if (m_pend >= 0) begin
            m_owner = m_pend; m_pend = -1; m_hold = 0;
            m_noe1 = !l[2 * m_owner]; m_noe2 = !l[2 * m_owner + 1];
        end else begin
            m_pend = pick(q, m_ptr);
            if (m_pend >= 0) m_sel = m_pend;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input logic [3:0] q, input logic [7:0] l);
        logic [3:0] exp_gnt;
        reset = r; req = q; lane = l;
        @(posedge clk);
        model_step(r, q, l);
        #1;
        exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        check("model_sel",  32'(sel),  32'(m_sel));
        check("model_noe1", 32'(noe1), 32'(m_noe1));
        check("model_noe2", 32'(noe2), 32'(m_noe2));
        check("model_gnt",  32'(gnt),  32'(exp_gnt));
        check("model_busy", 32'(busy), 32'((m_owner >= 0 || m_pend >= 0) ? 1 : 0));
        check("inv_onehot", $onehot0(gnt) ? 32'd1 : 32'd0, 32'd1);
        check("inv_noe_owner", ((!noe1 || !noe2) && !gnt[sel]) ? 32'd1 : 32'd0, 32'd0);
        check("inv_dead_cycle",
              (gnt != 4'd0 && prev_gnt != 4'd0 && gnt != prev_gnt) ? 32'd1 : 32'd0, 32'd0);
        prev_gnt = gnt;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] lane;
        logic [1:0] sel;
        logic       noe1;
        logic       noe2;
        logic [3:0] gnt;
        logic       busy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int fair_cnt;
        int order[$];
        logic [3:0] q;
        int exp_g;
        bit lrst;

        // Reset, single request on y1, ignored mid-grant lane change, then
        // y2-only grant, handover to 3 and lane pair 00 (reservation).
        vecs[0]  = '{1'b1, 4'hF, 8'h00, 2'd0, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[1]  = '{1'b1, 4'hF, 8'h00, 2'd0, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[2]  = '{1'b0, 4'h4, 8'h10, 2'd2, 1'b1, 1'b1, 4'h0, 1'b1};
        vecs[3]  = '{1'b0, 4'h4, 8'h10, 2'd2, 1'b0, 1'b1, 4'h4, 1'b1};
        vecs[4]  = '{1'b0, 4'h4, 8'h20, 2'd2, 1'b0, 1'b1, 4'h4, 1'b1};
        vecs[5]  = '{1'b0, 4'h0, 8'h20, 2'd2, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 8'h00, 2'd2, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[7]  = '{1'b0, 4'h1, 8'h02, 2'd0, 1'b1, 1'b1, 4'h0, 1'b1};
        vecs[8]  = '{1'b0, 4'h1, 8'h02, 2'd0, 1'b1, 1'b0, 4'h1, 1'b1};
        vecs[9]  = '{1'b0, 4'h1, 8'h00, 2'd0, 1'b1, 1'b0, 4'h1, 1'b1};
        vecs[10] = '{1'b0, 4'h9, 8'h00, 2'd0, 1'b1, 1'b0, 4'h1, 1'b1};
        vecs[11] = '{1'b0, 4'h8, 8'h00, 2'd3, 1'b1, 1'b1, 4'h0, 1'b1};
        vecs[12] = '{1'b0, 4'h8, 8'h00, 2'd3, 1'b1, 1'b1, 4'h8, 1'b1};
        vecs[13] = '{1'b0, 4'h0, 8'h00, 2'd3, 1'b1, 1'b1, 4'h0, 1'b0};

        reset = 1'b1; req = 4'h0; lane = 8'h00;

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].lane);
            check($sformatf("vec%0d_sel", i),  32'(sel),  32'(vecs[i].sel));
            check($sformatf("vec%0d_noe1", i), 32'(noe1), 32'(vecs[i].noe1));
            check($sformatf("vec%0d_noe2", i), 32'(noe2), 32'(vecs[i].noe2));
            check($sformatf("vec%0d_gnt", i),  32'(gnt),  32'(vecs[i].gnt));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
        end

        // Fairness: all four request, each lets go after three grant cycles.
        cycle(1'b1, 4'h0, 8'hFF);
        q = 4'hF;
        fair_cnt = 0;
        for (int c = 0; c < 40 && q != 4'd0; c++) begin
            cycle(1'b0, q, 8'hFF);
            if (gnt != 4'd0) begin
                if (order.size() == 0 || order[order.size() - 1] != idx_of(gnt))
                    order.push_back(idx_of(gnt));
                fair_cnt++;
                if (fair_cnt == 3) begin
                    q[idx_of(gnt)] = 1'b0;
                    fair_cnt = 0;
                end
            end else begin
                fair_cnt = 0;
            end
        end
        cycle(1'b0, 4'h0, 8'hFF);
        check("fair_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fair_order%0d", i),
                  (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i));

        // Hold limit: two requesters held constantly.
        cycle(1'b1, 4'h0, 8'hFF);
        for (int n = 1; n <= 16; n++) begin
            cycle(1'b0, 4'h3, 8'hFF);
            if (n == 1)                exp_g = 0;
            else if (!HOLD_EN)         exp_g = 1;
            else if ((n - 1) % 5 == 0) exp_g = 0;
            else                       exp_g = (((n - 1) / 5) % 2 == 1) ? 2 : 1;
            check($sformatf("hold_gnt_c%0d", n), 32'(gnt), 32'(exp_g));
        end

        // Reset mid-grant, then a fresh grant must still go through TURN.
        cycle(1'b1, 4'h0, 8'h04);
        cycle(1'b0, 4'h2, 8'h04);
        cycle(1'b0, 4'h2, 8'h04);
        check("rstg_pre_gnt",  32'(gnt),  32'h2);
        check("rstg_pre_noe1", 32'(noe1), 32'd0);
        cycle(1'b1, 4'h2, 8'h04);
        check("rstg_sel",  32'(sel),  32'd0);
        check("rstg_noe",  32'({noe1, noe2}), 32'h3);
        check("rstg_gnt",  32'(gnt),  32'd0);
        check("rstg_busy", 32'(busy), 32'd0);
        cycle(1'b0, 4'h2, 8'h04);
        check("rstg_turn_sel",  32'(sel),  32'd1);
        check("rstg_turn_gnt",  32'(gnt),  32'd0);
        check("rstg_turn_busy", 32'(busy), 32'd1);
        cycle(1'b0, 4'h2, 8'h04);
        check("rstg_regrant_gnt", 32'(gnt), 32'h2);
        check("rstg_regrant_noe", 32'({noe1, noe2}), 32'h1);

        // Random traffic with sticky requests and rare resets.
        q = 4'h0;
        for (int c = 0; c < 4096; c++) begin
            lrst = ($urandom_range(0, 299) == 0);
            q = q ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            cycle(lrst, q, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
